namco_cpuctl: RTL

- Parametrised CPU control unit for Namco-style multi-CPU arcade cores.
- Generalises the fixed 3-CPU reset/IRQ/NMI fan-out to NCPU channels.
- Adds a latched register map, VBLANK-edge IRQ generation, per-channel programmable periodic NMI and a power-on reset sequencer.
- Sits between the common I/O device bus (write side only) and the CPU cores' RSTS/IRQS/NMIS inputs.

---
 rtl/namco_cpuctl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/namco_cpuctl.sv
// CPU control unit for Namco-style multi-CPU cores: reset sequencing, VBLANK IRQs and periodic NMIs.
// Optional watchdog (register 0x20, WDOG_FRAMES parameter) is built when NAMCO_CPUCTL_WDOG_EN is defined.
module namco_cpuctl #(
    parameter int NCPU     = 3,
    parameter int RST_HOLD = 64,
    parameter int PRESC    = 3072,
    parameter int NMI_W    = 32
`ifdef NAMCO_CPUCTL_WDOG_EN
    ,
    parameter int WDOG_FRAMES = 8
`endif
) (
    input  logic            MCLK,
    input  logic            RESET_N,
    input  logic            WE,
    input  logic [5:0]      AD,
    input  logic [7:0]      DI,
    input  logic            VBLK,
    input  logic [NCPU-1:0] IACK,
    output logic [NCPU-1:0] RSTS,
    output logic [NCPU-1:0] IRQS,
    output logic [NCPU-1:0] NMIS
);

    localparam int RCW = $clog2(RST_HOLD + 1);
    localparam int PW  = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int WW  = $clog2(NMI_W + 1);

    logic                       rst0_q, rst0_d;
    logic [RCW-1:0]             rst_cnt_q, rst_cnt_d;
    logic                       sub_rst_q, sub_rst_d;
    logic                       vblk_s1_q, vblk_s1_d;
    logic                       vblk_s2_q, vblk_s2_d;
    logic                       vblk_s3_q, vblk_s3_d;
    logic [NCPU-1:0]            en_q, en_d;
    logic [NCPU-1:0]            pend_q, pend_d;
    logic [PW-1:0]              presc_q, presc_d;
    logic [NCPU-1:0][7:0]       period_q, period_d;
    logic [NCPU-1:0][7:0]       cnt_q, cnt_d;
    logic [NCPU-1:0][WW-1:0]    pulse_q, pulse_d;
`ifdef NAMCO_CPUCTL_WDOG_EN
    localparam int FW = $clog2(WDOG_FRAMES + 1);
    logic [FW-1:0]              frame_q, frame_d;
`endif

    logic vblk_rise;
    logic tick;
    logic sub_wr;
    logic sub_assert;

    // Channel 0 belongs to the sequencer; all other channels share the sub-CPU reset.
    generate
        for (genvar gi = 0; gi < NCPU; gi++) begin : g_out
            if (gi == 0) begin : g_main
                assign RSTS[gi] = rst0_q;
            end else begin : g_sub
                assign RSTS[gi] = sub_rst_q;
            end
            assign IRQS[gi] = pend_q[gi];
            assign NMIS[gi] = |pulse_q[gi];
        end
    endgenerate

    always_comb begin
        rst0_d     = rst0_q;
        rst_cnt_d  = rst_cnt_q;
        sub_rst_d  = sub_rst_q;
        vblk_s1_d  = VBLK;
        vblk_s2_d  = vblk_s1_q;
        vblk_s3_d  = vblk_s2_q;
        en_d       = en_q;
        pend_d     = pend_q;
        period_d   = period_q;
        cnt_d      = cnt_q;
        pulse_d    = pulse_q;
`ifdef NAMCO_CPUCTL_WDOG_EN
        frame_d    = frame_q;
`endif

        vblk_rise  = vblk_s2_q & ~vblk_s3_q;
        tick       = (presc_q == PW'(PRESC - 1));
        presc_d    = tick ? '0 : presc_q + 1'b1;

        if (rst0_q) begin
            rst_cnt_d = rst_cnt_q + 1'b1;
            if (rst_cnt_q == RCW'(RST_HOLD - 1)) begin
                rst0_d = 1'b0;
            end
        end

        sub_wr     = WE && (AD == 6'h08);
        sub_assert = sub_wr && !DI[0];
        if (sub_wr) begin
            sub_rst_d = ~DI[0];
        end

        for (int i = 0; i < NCPU; i++) begin
            // Order encodes priority: IACK < VBLANK set < enable-clear write.
            if (IACK[i]) begin
                pend_d[i] = 1'b0;
            end
            if (vblk_rise && en_q[i] && !RSTS[i]) begin
                pend_d[i] = 1'b1;
            end
            if (WE && (AD == 6'(i))) begin
                en_d[i] = DI[0];
                if (!DI[0]) begin
                    pend_d[i] = 1'b0;
                end
            end

            if (pulse_q[i] != '0) begin
                pulse_d[i] = pulse_q[i] - 1'b1;
            end
            if (tick && (period_q[i] != 8'd0) && !RSTS[i]) begin
                if (cnt_q[i] == period_q[i] - 8'd1) begin
                    cnt_d[i]   = 8'd0;
                    pulse_d[i] = WW'(NMI_W);
                end else begin
                    cnt_d[i] = cnt_q[i] + 8'd1;
                end
            end
            // A running pulse is left alone on a period change unless the period is zero.
            if (WE && (AD == 6'(16 + i))) begin
                period_d[i] = DI;
                cnt_d[i]    = 8'd0;
                if (DI == 8'd0) begin
                    pulse_d[i] = '0;
                end
            end

            if (sub_assert && (i != 0)) begin
                pend_d[i]  = 1'b0;
                cnt_d[i]   = 8'd0;
                pulse_d[i] = '0;
            end
        end

`ifdef NAMCO_CPUCTL_WDOG_EN
        if (rst0_q || (WE && (AD == 6'h20))) begin
            frame_d = '0;
        end else if (vblk_rise) begin
            frame_d = frame_q + 1'b1;
        end
        // Expiry behaves like a one-cycle reset that restarts the sequencer.
        if (!rst0_q && (frame_q == FW'(WDOG_FRAMES))) begin
            rst0_d    = 1'b1;
            rst_cnt_d = '0;
            sub_rst_d = 1'b1;
            vblk_s1_d = 1'b0;
            vblk_s2_d = 1'b0;
            vblk_s3_d = 1'b0;
            en_d      = '0;
            pend_d    = '0;
            presc_d   = '0;
            period_d  = '0;
            cnt_d     = '0;
            pulse_d   = '0;
            frame_d   = '0;
        end
`endif
    end

    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rst0_q    <= 1'b1;
            rst_cnt_q <= '0;
            sub_rst_q <= 1'b1;
            vblk_s1_q <= 1'b0;
            vblk_s2_q <= 1'b0;
            vblk_s3_q <= 1'b0;
            en_q      <= '0;
            pend_q    <= '0;
            presc_q   <= '0;
            period_q  <= '0;
            cnt_q     <= '0;
            pulse_q   <= '0;
`ifdef NAMCO_CPUCTL_WDOG_EN
            frame_q   <= '0;
`endif
        end else begin
            rst0_q    <= rst0_d;
            rst_cnt_q <= rst_cnt_d;
            sub_rst_q <= sub_rst_d;
            vblk_s1_q <= vblk_s1_d;
            vblk_s2_q <= vblk_s2_d;
            vblk_s3_q <= vblk_s3_d;
            en_q      <= en_d;
            pend_q    <= pend_d;
            presc_q   <= presc_d;
            period_q  <= period_d;
            cnt_q     <= cnt_d;
            pulse_q   <= pulse_d;
`ifdef NAMCO_CPUCTL_WDOG_EN
            frame_q   <= frame_d;
`endif
        end
    end

endmodule
